// File: rtl/mux_tree_pipe.sv
// M-to-1 multiplexer built as a binary tree of registered 2:1 stages with valid/ready flow control.
// Define MUX_TREE_STATS_EN to add the saturating out_count result counter.
module mux_tree_pipe #(
    parameter int N = 24,
    parameter int M = 8,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M*N-1:0] I,
    input  logic [SW-1:0]  S,
    input  logic           en,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   O,
    output logic           out_valid,
`ifdef MUX_TREE_STATS_EN
    output logic [15:0]    out_count,
`endif
    input  logic           out_ready
);

    genvar k;
    generate
        for (k = 0; k < SW; k++) begin : g_stg
            localparam int CIN  = M >> k;
            localparam int COUT = M >> (k + 1);
            localparam int SIW  = SW - k;

            logic [CIN*N-1:0]  data_in;
            logic [SIW-1:0]    sel_in;
            logic              vld_in;
            logic              take;
            logic              load;
            logic [COUT*N-1:0] mux_out;
            logic [COUT*N-1:0] data_p;
            logic              vld_p;

            if (k == 0) begin : g_src
                assign data_in = en ? I : '0;
                assign sel_in  = S;
                assign vld_in  = in_valid;
            end else begin : g_src
                assign data_in = g_stg[k-1].data_p;
                assign sel_in  = g_stg[k-1].g_sel.sel_p;
                assign vld_in  = g_stg[k-1].vld_p;
            end

            // take: whatever sits downstream consumes this stage's contents at the next edge
            if (k == SW - 1) begin : g_dn
                assign take = out_ready;
            end else begin : g_dn
                assign take = g_stg[k+1].load;
            end

            assign load = vld_in & (~vld_p | take);

            always_comb begin
                mux_out = '0;
                for (int j = 0; j < COUT; j++) begin
                    mux_out[j*N +: N] = sel_in[0] ? data_in[(2*j+1)*N +: N] : data_in[2*j*N +: N];
                end
            end

            // ---- stage k register boundary ----
            always_ff @(posedge clk) begin
                if (!rst) begin
                    data_p <= '0;
                    vld_p  <= 1'b0;
                end else if (load) begin
                    data_p <= mux_out;
                    vld_p  <= 1'b1;
                end else if (take) begin
                    vld_p  <= 1'b0;
                end
            end

            // Select bits not yet consumed travel with their operands
            if (SIW > 1) begin : g_sel
                logic [SIW-2:0] sel_p;
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sel_p <= '0;
                    end else if (load) begin
                        sel_p <= sel_in[SIW-1:1];
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = ~g_stg[0].vld_p | g_stg[0].take;
    assign O         = g_stg[SW-1].data_p;
    assign out_valid = g_stg[SW-1].vld_p;

`ifdef MUX_TREE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= sat_inc(out_count);
        end
    end
`else
    // No result counter in this build.
`endif

endmodule
